// File: rtl/and_result_checker.sv
// and_result_checker
// Self-checking stage placed after the 4-bit and_gate. On every valid beat of
// a run it compares the gate result t against a & b, counts checked beats and
// mismatches, captures the first failing vector and finally reports the
// verdict through the done/pass outputs.
//
// Input qualification: a, b and t are sampled only on rising edges where
// in_valid=1 and the checker is in RUN. There is no back-pressure (no ready);
// in RUN every valid beat is accepted in the same cycle. In IDLE and DONE,
// in_valid is ignored entirely.
//
// NUM_VEC must lie in 1 .. 2**CNT_W-1 so that checked_cnt can never wrap
// before the run terminates.
module and_result_checker #(
    parameter int WIDTH   = 4,
    parameter int NUM_VEC = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] t,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] checked_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0] first_a,
    output logic [WIDTH-1:0] first_b,
    output logic [WIDTH-1:0] first_t,
    output logic [CNT_W-1:0] first_idx,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // checked_cnt value that closes a run
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VEC);
    // saturation ceiling of the mismatch counter
    localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t             state_q,       state_d;
    logic               busy_q,        busy_d;
    logic               done_q,        done_d;
    logic               pass_q,        pass_d;
    logic               abort_flag_q,  abort_flag_d;
    logic               first_seen_q,  first_seen_d;
    logic [CNT_W-1:0]   checked_cnt_q, checked_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q,     err_cnt_d;
    logic [WIDTH-1:0]   first_a_q,     first_a_d;
    logic [WIDTH-1:0]   first_b_q,     first_b_d;
    logic [WIDTH-1:0]   first_t_q,     first_t_d;
    logic [CNT_W-1:0]   first_idx_q,   first_idx_d;

    // ------------------------------------------------------------------
    // Beat evaluation
    // ------------------------------------------------------------------
    logic               beat_accept;
    logic               beat_mismatch;
    logic [CNT_W-1:0]   cnt_inc;
    logic               run_finish;

    // Qualify the beat and form the full-width comparison against a & b
    always_comb begin
        beat_accept   = (state_q == RUN) && in_valid;
        beat_mismatch = (t != (a & b));
        cnt_inc       = checked_cnt_q + CNT_W'(1);
        run_finish    = (beat_accept && (cnt_inc == LAST_CNT)) || abort;
    end

    // Next-state and next-output logic: hold everything unless an event acts
    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = done_q;
        pass_d        = pass_q;
        abort_flag_d  = abort_flag_q;
        first_seen_d  = first_seen_q;
        checked_cnt_d = checked_cnt_q;
        err_cnt_d     = err_cnt_q;
        first_a_d     = first_a_q;
        first_b_d     = first_b_q;
        first_t_d     = first_t_q;
        first_idx_d   = first_idx_q;

        case (state_q)
            // IDLE and DONE share the launch path; start beats a
            // simultaneous abort here because abort has nothing to end
            IDLE, DONE: begin
                if (start) begin
                    state_d       = RUN;
                    busy_d        = 1'b1;
                    done_d        = 1'b0;
                    pass_d        = 1'b0;
                    abort_flag_d  = 1'b0;
                    first_seen_d  = 1'b0;
                    checked_cnt_d = '0;
                    err_cnt_d     = '0;
                    first_a_d     = '0;
                    first_b_d     = '0;
                    first_t_d     = '0;
                    first_idx_d   = '0;
                end
            end

            // start is ignored here; abort takes effect, but a beat
            // arriving in the same cycle is still counted and compared
            RUN: begin
                if (beat_accept) begin
                    checked_cnt_d = cnt_inc;
                    if (beat_mismatch) begin
                        if (err_cnt_q != ERR_MAX) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                        if (!first_seen_q) begin
                            first_seen_d = 1'b1;
                            first_a_d    = a;
                            first_b_d    = b;
                            first_t_d    = t;
                            first_idx_d  = checked_cnt_q;
                        end
                    end
                end

                if (abort) begin
                    abort_flag_d = 1'b1;
                end

                // busy, done and pass all switch on the same edge so pass
                // is already settled when done first reads 1
                if (run_finish) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0) && !abort_flag_d;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    // State and result registers; synchronous active-low reset wipes the run
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            abort_flag_q  <= 1'b0;
            first_seen_q  <= 1'b0;
            checked_cnt_q <= '0;
            err_cnt_q     <= '0;
            first_a_q     <= '0;
            first_b_q     <= '0;
            first_t_q     <= '0;
            first_idx_q   <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            abort_flag_q  <= abort_flag_d;
            first_seen_q  <= first_seen_d;
            checked_cnt_q <= checked_cnt_d;
            err_cnt_q     <= err_cnt_d;
            first_a_q     <= first_a_d;
            first_b_q     <= first_b_d;
            first_t_q     <= first_t_d;
            first_idx_q   <= first_idx_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        busy        = busy_q;
        done        = done_q;
        pass        = pass_q;
        checked_cnt = checked_cnt_q;
        err_cnt     = err_cnt_q;
        first_a     = first_a_q;
        first_b     = first_b_q;
        first_t     = first_t_q;
        first_idx   = first_idx_q;
        state_dbg   = state_q;
    end

endmodule
